// File: rtl/life_pkg.sv
// Shared types, constants and the Game-of-Life cell rule for the step sequencer.
package life_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_PLOT = 3'd1,
        ST_SCAN      = 3'd2,
        ST_SCAN_PLOT = 3'd3,
        ST_SWAP      = 3'd4
    } life_state_e;

    localparam logic [2:0] COLOUR_ALIVE = 3'b111;
    localparam logic [2:0] COLOUR_DEAD  = 3'b000;

    // Birth on exactly three neighbours, survival on two or three.
    function automatic logic life_rule(input logic alive, input logic [3:0] n);
        return (n == 4'd3) || (alive && (n == 4'd2));
    endfunction

endpackage

// File: rtl/life_neighbour_count.sv
// Combinational count of live 8-neighbours of cell (row,col); cells outside the
// grid count as dead. The grid is embedded in a zero border so every 3x3 window
// is an in-range slice and no edge special-casing is needed at run time.
module life_neighbour_count
    import life_pkg::*;
#(
    parameter int GRID_W = 4,
    parameter int GRID_H = 4,
    parameter int ROW_W  = $clog2(GRID_H),
    parameter int COL_W  = $clog2(GRID_W)
) (
    input  logic [GRID_W*GRID_H-1:0] i_grid,
    input  logic [ROW_W-1:0]         i_row,
    input  logic [COL_W-1:0]         i_col,
    output logic [3:0]               o_count
);

    localparam int PW     = GRID_W + 2;
    localparam int PH     = GRID_H + 2;
    localparam int BASE_W = $clog2(PW * PH);

    logic [PW*PH-1:0]  w_padded;
    logic [BASE_W-1:0] w_base_top;
    logic [BASE_W-1:0] w_base_ml;
    logic [BASE_W-1:0] w_base_mr;
    logic [BASE_W-1:0] w_base_bot;
    logic [2:0]        w_top;
    logic [2:0]        w_bot;
    logic              w_ml;
    logic              w_mr;

    genvar gi, gj;
    generate
        for (gi = 0; gi < PH; gi++) begin : g_row
            for (gj = 0; gj < PW; gj++) begin : g_col
                if (gi == 0 || gi == PH - 1 || gj == 0 || gj == PW - 1) begin : g_border
                    assign w_padded[gi*PW + gj] = 1'b0;
                end else begin : g_cell
                    assign w_padded[gi*PW + gj] = i_grid[(gi-1)*GRID_W + (gj-1)];
                end
            end
        end
    endgenerate

    // Grid cell (r,c) sits at padded (r+1,c+1), so its window starts at padded (r,c).
    always_comb begin
        w_base_top = BASE_W'(int'(i_row) * PW + int'(i_col));
        w_base_ml  = BASE_W'((int'(i_row) + 1) * PW + int'(i_col));
        w_base_mr  = BASE_W'((int'(i_row) + 1) * PW + int'(i_col) + 2);
        w_base_bot = BASE_W'((int'(i_row) + 2) * PW + int'(i_col));
        w_top      = w_padded[w_base_top +: 3];
        w_bot      = w_padded[w_base_bot +: 3];
        w_ml       = w_padded[w_base_ml];
        w_mr       = w_padded[w_base_mr];
    end

    assign o_count = {3'b000, w_top[0]} + {3'b000, w_top[1]} + {3'b000, w_top[2]}
                   + {3'b000, w_ml}     + {3'b000, w_mr}
                   + {3'b000, w_bot[0]} + {3'b000, w_bot[1]} + {3'b000, w_bot[2]};

endmodule

// File: rtl/life_step_sequencer.sv
// Game-of-Life sequencer: owns the cell grid, accepts cell loads, computes one
// generation per step or rate tick, and emits one pixel write per changed cell.
module life_step_sequencer
    import life_pkg::*;
#(
    parameter int GRID_W   = 4,
    parameter int GRID_H   = 4,
    parameter int COORD_W  = 8,
    parameter int TICK_DIV = 5000000,
    parameter int GEN_W    = 16
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_run,
    input  logic               i_step,
    input  logic               i_load_valid,
    input  logic [COORD_W-1:0] i_load_x,
    input  logic [COORD_W-1:0] i_load_y,
    output logic               o_load_ready,
    output logic [COORD_W-1:0] o_plot_x,
    output logic [COORD_W-1:0] o_plot_y,
    output logic [2:0]         o_plot_colour,
    output logic               o_plot_valid,
    input  logic               i_plot_ready,
    output logic               o_busy,
    output logic [GEN_W-1:0]   o_generation
);

    localparam int N_CELLS = GRID_W * GRID_H;
    localparam int CELL_W  = $clog2(N_CELLS);
    localparam int ROW_W   = $clog2(GRID_H);
    localparam int COL_W   = $clog2(GRID_W);
    localparam int TICK_W  = $clog2(TICK_DIV);

    localparam logic [COL_W-1:0]  COL_LAST    = COL_W'(GRID_W - 1);
    localparam logic [CELL_W-1:0] CELL_LAST   = CELL_W'(N_CELLS - 1);
    localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(TICK_DIV - 1);

    life_state_e          r_state;
    life_state_e          w_state_next;
    logic [N_CELLS-1:0]   r_cur;
    logic [N_CELLS-1:0]   r_nxt;
    logic [CELL_W-1:0]    r_idx;
    logic [ROW_W-1:0]     r_row;
    logic [COL_W-1:0]     r_col;
    logic [COORD_W-1:0]   r_plot_x;
    logic [COORD_W-1:0]   r_plot_y;
    logic [2:0]           r_plot_colour;
    logic [GEN_W-1:0]     r_generation;
    logic [TICK_W-1:0]    r_tick_cnt;
    logic                 r_tick_pend;

    logic [3:0]           w_ncount;
    logic                 w_cur_cell;
    logic                 w_next_cell;
    logic                 w_last_cell;
    logic                 w_tick_fire;
    logic                 w_load_in_range;
    logic [CELL_W-1:0]    w_load_idx;
    logic                 w_load_set;
    logic                 w_start_scan;
    logic                 w_scan_plot;
    logic                 w_advance;
    logic                 w_do_swap;

    life_neighbour_count #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H),
        .ROW_W  (ROW_W),
        .COL_W  (COL_W)
    ) u_count (
        .i_grid  (r_cur),
        .i_row   (r_row),
        .i_col   (r_col),
        .o_count (w_ncount)
    );

    assign w_cur_cell      = r_cur[r_idx];
    assign w_next_cell     = life_rule(w_cur_cell, w_ncount);
    assign w_last_cell     = (r_idx == CELL_LAST);
    assign w_tick_fire     = i_run && (r_tick_cnt == '0);
    assign w_load_in_range = (int'(i_load_x) < GRID_W) && (int'(i_load_y) < GRID_H);
    assign w_load_idx      = CELL_W'(int'(i_load_y) * GRID_W + int'(i_load_x));
    assign w_do_swap       = (r_state == ST_SWAP);

    // Next-state decode plus single-cycle control strobes for the datapath.
    always_comb begin
        w_state_next = r_state;
        w_load_set   = 1'b0;
        w_start_scan = 1'b0;
        w_scan_plot  = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A load always wins the cycle; an out-of-range load is simply consumed.
                if (i_load_valid) begin
                    if (w_load_in_range) begin
                        w_load_set   = 1'b1;
                        w_state_next = ST_LOAD_PLOT;
                    end
                end else if (i_step || r_tick_pend) begin
                    w_start_scan = 1'b1;
                    w_state_next = ST_SCAN;
                end
            end
            ST_LOAD_PLOT: begin
                if (i_plot_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (w_next_cell != w_cur_cell) begin
                    w_scan_plot  = 1'b1;
                    w_state_next = ST_SCAN_PLOT;
                end else begin
                    w_advance    = 1'b1;
                    w_state_next = w_last_cell ? ST_SWAP : ST_SCAN;
                end
            end
            ST_SCAN_PLOT: begin
                if (i_plot_ready) begin
                    w_advance    = 1'b1;
                    w_state_next = w_last_cell ? ST_SWAP : ST_SCAN;
                end
            end
            ST_SWAP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Scan index walks the grid row-major; it stays put while a plot is stalled.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_idx <= '0;
            r_row <= '0;
            r_col <= '0;
        end else if (w_start_scan) begin
            r_idx <= '0;
            r_row <= '0;
            r_col <= '0;
        end else if (w_advance && !w_last_cell) begin
            r_idx <= r_idx + 1'b1;
            if (r_col == COL_LAST) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Grid storage: loads set cur, the scan fills nxt, and swap publishes nxt as cur.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_cur <= '0;
            r_nxt <= '0;
        end else begin
            if (w_load_set) begin
                r_cur[w_load_idx] <= 1'b1;
            end
            if (r_state == ST_SCAN) begin
                r_nxt[r_idx] <= w_next_cell;
            end
            if (w_do_swap) begin
                r_cur <= r_nxt;
            end
        end
    end

    // Pixel registers are captured only when a plot is launched, so they hold during stalls.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_plot_x      <= '0;
            r_plot_y      <= '0;
            r_plot_colour <= COLOUR_DEAD;
        end else if (w_load_set) begin
            r_plot_x      <= i_load_x;
            r_plot_y      <= i_load_y;
            r_plot_colour <= COLOUR_ALIVE;
        end else if (w_scan_plot) begin
            r_plot_x      <= COORD_W'(r_col);
            r_plot_y      <= COORD_W'(r_row);
            r_plot_colour <= w_next_cell ? COLOUR_ALIVE : COLOUR_DEAD;
        end
    end

    // Completed-generation counter, wrapping naturally.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_generation <= '0;
        end else if (w_do_swap) begin
            r_generation <= r_generation + 1'b1;
        end
    end

    // Rate divider and one-deep pending tick; a tick landing on the cycle a
    // generation starts is merged into that generation.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_tick_cnt  <= TICK_RELOAD;
            r_tick_pend <= 1'b0;
        end else begin
            if (i_run) begin
                r_tick_cnt <= (r_tick_cnt == '0) ? TICK_RELOAD : r_tick_cnt - 1'b1;
            end
            if (w_start_scan) begin
                r_tick_pend <= 1'b0;
            end else if (w_tick_fire) begin
                r_tick_pend <= 1'b1;
            end
        end
    end

    assign o_load_ready  = (r_state == ST_IDLE) && !i_reset;
    assign o_busy        = (r_state != ST_IDLE);
    assign o_plot_valid  = (r_state == ST_LOAD_PLOT) || (r_state == ST_SCAN_PLOT);
    assign o_plot_x      = r_plot_x;
    assign o_plot_y      = r_plot_y;
    assign o_plot_colour = r_plot_colour;
    assign o_generation  = r_generation;

endmodule
